uart_telemetry_tx: RTL and testbench
====================================

// Module: uart_telemetry_tx
// PURPOSE
//  UART 8N1 transmitter that returns status to the host PC, the opposite direction of the uart_rxd flash path.
//  Sends an ACK packet for each applied flash command (uart_flash_wen/cmd) and a FRAME packet per finished rtx frame.
//  Lives in clk_rtx domain; drives uart_txd pin through top_level.
// PARAMETERS
//  CLK_HZ  100_000_000  input clock frequency
//  BAUD    115_200      line rate; BAUD_DIV = CLK_HZ/BAUD (integer floor, 868 at defaults), cycles per bit
// PORTS
//  clk            in   1   rtx clock
//  rst            in   1   synchronous, active-high reset
//  ack_valid      in   1   1-cycle pulse: flash command applied
//  ack_cmd        in   8   command byte, sampled with ack_valid
//  frame_done     in   1   1-cycle pulse: last pixel of frame written
//  frame_count    in   16  frame counter, sampled with frame_done
//  tx             out  1   serial line, idle high
//  busy           out  1   high when FSM not IDLE or any slot pending
//  ack_overflow   out  1   1-cycle pulse: ack_valid dropped (slot full)
// BEHAVIOUR
//  Reset: tx=1, busy=0, ack_overflow=0, both slots empty, all counters 0, FSM IDLE. Reset mid-byte aborts: tx=1 next edge.
//  Packets (bytes in order):
//   ACK   = 0xA5, cmd, 0xA5^cmd                                    (3 bytes)
//   FRAME = 0x5A, cnt[7:0], cnt[15:8], 0x5A^cnt[7:0]^cnt[15:8]     (4 bytes)
//  Pending slots (one entry each):
//   ACK slot: ack_valid with slot empty -> store cmd. With slot full -> drop new, keep old, ack_overflow=1 next cycle.
//   FRAME slot: frame_done always stores frame_count; overwrites an older pending value (newest wins), no flag.
//   Same-cycle set and FSM-clear of a slot: set wins (new entry retained and sent later).
//  Packet FSM: IDLE -> SEND -> IDLE.
//   IDLE: if ACK slot full, load ACK packet, clear ACK slot; else if FRAME slot full, load FRAME, clear FRAME slot.
//    ACK has strict priority. Packet bytes are latched at load; later slot writes do not alter in-flight packet.
//   SEND: byte index 0..N-1; after stop bit of last byte -> IDLE.
//  Byte FSM (inside SEND): START(tx=0) -> DATA bits 0..7, LSB first -> STOP(tx=1); each bit exactly BAUD_DIV cycles.
//   Bytes within a packet are back-to-back: next START follows STOP with no extra idle.
//   Between packets: exactly 1 IDLE cycle (tx=1) before the next START.
//  Latency: ack_valid sampled at edge E while IDLE and slots empty -> slot set at E, packet loaded at E+1,
//   tx low from E+2. Frame path identical.
//  tx is a registered output (glitch-free). Bit counter width $clog2(BAUD_DIV).
//  busy asserts at edge E (slot set), deasserts on the edge FSM enters IDLE with both slots empty.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> BAUD_DIV=10)
//  ack_valid, cmd=0x81 -> tx bytes A5,81,24; start bit low at E+2; each bit 10 cycles; 300 cycles + 1 idle.
//  frame_done, frame_count=0x1234 -> bytes 5A,34,12,7C; no gaps between bytes.
//  frame_done and ack_valid(cmd=0x03) same cycle -> ACK A5,03,A6 sent first, then FRAME packet.
//  ack_valid x3 during a transmission -> 2nd stored, 3rd dropped with ack_overflow pulse; exactly two ACK packets sent.
//  frame_done cnt=5 then cnt=6 while busy -> single FRAME packet with cnt=6.
//  rst asserted mid DATA bit -> tx=1, busy=0 next edge; no further bytes; new ack_valid after reset sends full packet.

Source files
------------

// File: rtl/uart_telemetry_tx_if.sv
// Host-status handshake bundle between the rtx-domain event sources and the telemetry UART.
// Pure wiring, no latency; the transmitter has no backpressure, it reports drops on ack_overflow.
interface uart_telemetry_tx_if;
    logic        ack_valid;
    logic [7:0]  ack_cmd;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        tx;
    logic        busy;
    logic        ack_overflow;

    modport master (
        output ack_valid, ack_cmd, frame_done, frame_count,
        input  tx, busy, ack_overflow
    );

    modport slave (
        input  ack_valid, ack_cmd, frame_done, frame_count,
        output tx, busy, ack_overflow
    );
endinterface

// File: rtl/uart_telemetry_tx.sv
// 8N1 status transmitter: ACK packets per flash command, FRAME packets per finished frame.
// Latency: event at edge E -> packet loaded E+1 -> start bit on tx from E+2.
// No backpressure: one pending slot each; a second ACK is dropped with a pulse, FRAME keeps the newest.
module uart_telemetry_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic             clk,
    input  logic             rst,
    uart_telemetry_tx_if.slave bus
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [7:0] ACK_SYNC   = 8'hA5;
    localparam logic [7:0] FRAME_SYNC = 8'h5A;

    typedef enum logic {PKT_IDLE, PKT_SEND} pkt_state_e;
    typedef enum logic [1:0] {BIT_START, BIT_DATA, BIT_STOP} bit_phase_e;

    // bytes[0] goes out first; last is the index of the final byte
    typedef struct packed {
        logic [3:0][7:0] bytes;
        logic [1:0]      last;
    } pkt_t;

    pkt_state_e       pkt_state_q, pkt_state_d;
    bit_phase_e       phase_q, phase_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    pkt_t             pkt_q, pkt_d;
    logic             tx_q, tx_d;
    logic             ack_full_q, ack_full_d;
    logic [7:0]       ack_slot_q, ack_slot_d;
    logic             frame_full_q, frame_full_d;
    logic [15:0]      frame_slot_q, frame_slot_d;
    logic             ack_ovf_q, ack_ovf_d;
    logic             ack_clr, frame_clr;
    logic [7:0]       cur_byte;

    assign cur_byte = pkt_q.bytes[byte_idx_q];

    always_comb begin
        pkt_state_d = pkt_state_q;
        phase_d     = phase_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        pkt_d       = pkt_q;
        tx_d        = 1'b1;
        ack_clr     = 1'b0;
        frame_clr   = 1'b0;

        case (pkt_state_q)
            PKT_IDLE: begin
                if (ack_full_q || frame_full_q) begin
                    pkt_state_d = PKT_SEND;
                    phase_d     = BIT_START;
                    baud_cnt_d  = '0;
                    bit_idx_d   = '0;
                    byte_idx_d  = '0;
                end
                if (ack_full_q) begin
                    ack_clr    = 1'b1;
                    pkt_d.bytes = {8'h00, ACK_SYNC ^ ack_slot_q, ack_slot_q, ACK_SYNC};
                    pkt_d.last  = 2'd2;
                end else if (frame_full_q) begin
                    frame_clr   = 1'b1;
                    pkt_d.bytes = {FRAME_SYNC ^ frame_slot_q[7:0] ^ frame_slot_q[15:8],
                                   frame_slot_q[15:8], frame_slot_q[7:0], FRAME_SYNC};
                    pkt_d.last  = 2'd3;
                end
            end
            PKT_SEND: begin
                case (phase_q)
                    BIT_START: tx_d = 1'b0;
                    BIT_DATA:  tx_d = cur_byte[bit_idx_q];
                    default:   tx_d = 1'b1;
                endcase
                if (baud_cnt_q == CNT_LAST) begin
                    baud_cnt_d = '0;
                    case (phase_q)
                        BIT_START: begin
                            phase_d   = BIT_DATA;
                            bit_idx_d = '0;
                        end
                        BIT_DATA: begin
                            if (bit_idx_q == 3'd7) phase_d = BIT_STOP;
                            else                   bit_idx_d = bit_idx_q + 3'd1;
                        end
                        default: begin
                            // back-to-back bytes: next start bit follows the stop bit directly
                            if (byte_idx_q == pkt_q.last) begin
                                pkt_state_d = PKT_IDLE;
                            end else begin
                                byte_idx_d = byte_idx_q + 2'd1;
                                phase_d    = BIT_START;
                            end
                        end
                    endcase
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: pkt_state_d = PKT_IDLE;
        endcase
    end

    // a new event in the same cycle the FSM drains the slot is kept, not lost
    always_comb begin
        ack_full_d   = ack_full_q;
        ack_slot_d   = ack_slot_q;
        ack_ovf_d    = 1'b0;
        frame_full_d = frame_full_q;
        frame_slot_d = frame_slot_q;

        if (ack_clr) ack_full_d = 1'b0;
        if (bus.ack_valid) begin
            if (ack_full_q && !ack_clr) begin
                ack_ovf_d = 1'b1;
            end else begin
                ack_full_d = 1'b1;
                ack_slot_d = bus.ack_cmd;
            end
        end

        if (frame_clr) frame_full_d = 1'b0;
        if (bus.frame_done) begin
            frame_full_d = 1'b1;
            frame_slot_d = bus.frame_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_state_q  <= PKT_IDLE;
            phase_q      <= BIT_START;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            pkt_q        <= '0;
            tx_q         <= 1'b1;
            ack_full_q   <= 1'b0;
            ack_slot_q   <= '0;
            frame_full_q <= 1'b0;
            frame_slot_q <= '0;
            ack_ovf_q    <= 1'b0;
        end else begin
            pkt_state_q  <= pkt_state_d;
            phase_q      <= phase_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            pkt_q        <= pkt_d;
            tx_q         <= tx_d;
            ack_full_q   <= ack_full_d;
            ack_slot_q   <= ack_slot_d;
            frame_full_q <= frame_full_d;
            frame_slot_q <= frame_slot_d;
            ack_ovf_q    <= ack_ovf_d;
        end
    end

    assign bus.tx           = tx_q;
    assign bus.busy         = (pkt_state_q != PKT_IDLE) || ack_full_q || frame_full_q;
    assign bus.ack_overflow = ack_ovf_q;
endmodule

// File: tb/tb_uart_telemetry_tx.sv
// Directed bench for uart_telemetry_tx at BAUD_DIV=10: a line decoder rebuilds bytes and start times from tx.
module tb_uart_telemetry_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] rx_b[$];
    int         rx_t[$];

    uart_telemetry_tx_if bus();

    uart_telemetry_tx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // line decoder: sample each bit in its middle; a byte cut by reset is discarded
    initial begin
        logic [7:0] b;
        logic       ok;
        int         t0;
        forever begin
            @(negedge clk);
            if (!rst && bus.tx === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                b  = '0;
                for (int i = 1; i <= 95; i++) begin
                    @(negedge clk);
                    if (rst) ok = 1'b0;
                    if (i >= 15 && i <= 85 && (i % 10) == 5) b[(i - 15) / 10] = bus.tx;
                    if (i == 95 && ok) check("stop_bit", {31'd0, bus.tx}, 32'd1);
                end
                if (ok) begin
                    rx_b.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic a, input logic [7:0] cmd, input logic f,
                         input logic [15:0] cnt, output int t_e);
        bus.ack_valid   = a;
        bus.ack_cmd     = cmd;
        bus.frame_done  = f;
        bus.frame_count = cnt;
        @(negedge clk);
        bus.ack_valid  = 1'b0;
        bus.frame_done = 1'b0;
        t_e = cyc;
    endtask

    task automatic wait_idle(input string tag, output int t_fall);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        t_fall = cyc;
        if (n >= 3000) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic expect_seq(input string tag, input int n, input logic [63:0] exp_b,
                              input int t_first, input int pkt1_len);
        check({tag, "_count"}, rx_b.size(), n);
        for (int k = 0; k < n && k < rx_b.size(); k++) begin
            check($sformatf("%s_byte%0d", tag, k), {24'd0, rx_b[k]}, {24'd0, exp_b[8*k +: 8]});
            check($sformatf("%s_time%0d", tag, k), rx_t[k],
                  t_first + 100 * k + ((k >= pkt1_len) ? 1 : 0));
        end
        rx_b.delete();
        rx_t.delete();
    endtask

    initial begin
        int t_e, t_f, t_x;
        bus.ack_valid   = 1'b0;
        bus.ack_cmd     = '0;
        bus.frame_done  = 1'b0;
        bus.frame_count = '0;
        repeat (4) @(negedge clk);
        check("rst_tx", {31'd0, bus.tx}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ovf", {31'd0, bus.ack_overflow}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_tx", {31'd0, bus.tx}, 32'd1);

        // single ACK
        pulse(1'b1, 8'h81, 1'b0, 16'h0, t_e);
        check("ack_busy", {31'd0, bus.busy}, 32'd1);
        wait_idle("ack", t_f);
        check("ack_busy_fall", t_f - t_e, 32'd301);
        expect_seq("ack", 3, 64'h2481A5, t_e + 2, 3);

        // single FRAME
        pulse(1'b0, 8'h0, 1'b1, 16'h1234, t_e);
        wait_idle("frame", t_f);
        expect_seq("frame", 4, 64'h7C12345A, t_e + 2, 4);

        // simultaneous: ACK has priority, FRAME one idle cycle later
        pulse(1'b1, 8'h03, 1'b1, 16'hBEEF, t_e);
        wait_idle("both", t_f);
        expect_seq("both", 7, 64'h0BBEEF5AA603A5, t_e + 2, 3);

        // three ACKs: second queued, third dropped
        pulse(1'b1, 8'h10, 1'b0, 16'h0, t_e);
        repeat (20) @(negedge clk);
        pulse(1'b1, 8'h20, 1'b0, 16'h0, t_x);
        check("ovf_second", {31'd0, bus.ack_overflow}, 32'd0);
        pulse(1'b1, 8'h30, 1'b0, 16'h0, t_x);
        check("ovf_third", {31'd0, bus.ack_overflow}, 32'd1);
        @(negedge clk);
        check("ovf_pulse_end", {31'd0, bus.ack_overflow}, 32'd0);
        wait_idle("ovf", t_f);
        expect_seq("ovf", 6, 64'h8520A5B510A5, t_e + 2, 3);

        // FRAME newest wins while busy
        pulse(1'b1, 8'h55, 1'b0, 16'h0, t_e);
        repeat (10) @(negedge clk);
        pulse(1'b0, 8'h0, 1'b1, 16'h0005, t_x);
        repeat (10) @(negedge clk);
        pulse(1'b0, 8'h0, 1'b1, 16'h0006, t_x);
        wait_idle("newest", t_f);
        expect_seq("newest", 7, 64'h5C00065AF055A5, t_e + 2, 3);

        // reset during data bit 1 of 0xA5 (a zero bit)
        pulse(1'b1, 8'h81, 1'b0, 16'h0, t_e);
        while (cyc < t_e + 25) @(negedge clk);
        check("pre_rst_tx", {31'd0, bus.tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", {31'd0, bus.tx}, 32'd1);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        check("post_rst_quiet", rx_b.size(), 32'd0);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        rx_b.delete();
        rx_t.delete();
        pulse(1'b1, 8'h42, 1'b0, 16'h0, t_e);
        wait_idle("after_rst", t_f);
        expect_seq("after_rst", 3, 64'hE742A5, t_e + 2, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
